// File: rtl/code_search_ctrl.sv
// Steps one channel through a code-shift search: seek each bin's target, settle, dwell, dump.
// Define CODE_SEARCH_TIMEOUT_EN to add a per-bin SEEK/SETTLE watchdog that aborts with cfg_err.
module code_search_ctrl #(
    parameter int unsigned CS_WIDTH    = 11,
    parameter int unsigned CS_MAX      = 2045,
    parameter int unsigned BIN_WIDTH   = 11,
    parameter int unsigned DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [CS_WIDTH-1:0]    cs_start,
    input  logic [CS_WIDTH-1:0]    cs_step,
    input  logic [BIN_WIDTH-1:0]   num_bins,
    input  logic [DWELL_WIDTH-1:0] dwell_len,
    input  logic                   sample_en,
    input  logic                   target_reached,
    input  logic                   seeking,
    output logic                   seek_en,
    output logic [CS_WIDTH-1:0]    seek_target,
    output logic                   acc_clear,
    output logic                   dump_valid,
    input  logic                   dump_ready,
    output logic [BIN_WIDTH-1:0]   bin_index,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_err
);

    typedef enum logic [2:0] {StIdle, StSeek, StSettle, StDwell, StDump, StFin} state_e;

    localparam logic [CS_WIDTH:0] CsMaxW = (CS_WIDTH+1)'(CS_MAX);
    localparam logic [CS_WIDTH:0] CsMod  = (CS_WIDTH+1)'(CS_MAX + 1);

    state_e                 state;
    logic [CS_WIDTH-1:0]    step_q;
    logic [BIN_WIDTH-1:0]   nbins_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic [DWELL_WIDTH-1:0] dwell_cnt;
    logic [CS_WIDTH:0]      nxt_sum;
    logic [CS_WIDTH:0]      nxt_wrap;
    logic                   cfg_ok;
    logic                   last_bin;
    logic                   wd_fire;

    assign cfg_ok   = ({1'b0, cs_start} <= CsMaxW) && ({1'b0, cs_step} <= CsMaxW);
    // One extra bit so the sum of two legal shifts cannot overflow before wrapping.
    assign nxt_sum  = {1'b0, seek_target} + {1'b0, step_q};
    assign nxt_wrap = (nxt_sum > CsMaxW) ? (nxt_sum - CsMod) : nxt_sum;
    assign last_bin = (bin_index == (nbins_q - BIN_WIDTH'(1)));

`ifdef CODE_SEARCH_TIMEOUT_EN
    localparam int unsigned WdLimit = 2 * (CS_MAX + 1) + 8;
    localparam int unsigned WdWidth = $clog2(WdLimit + 1);

    logic [WdWidth-1:0] wd_cnt;

    assign wd_fire = ((state == StSeek) || (state == StSettle)) &&
                     (wd_cnt == WdWidth'(WdLimit - 1));

    // Cleared whenever the FSM leaves SEEK/SETTLE, so the budget applies per bin.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if ((state == StSeek) || (state == StSettle)) begin
            wd_cnt <= wd_cnt + WdWidth'(1);
        end else begin
            wd_cnt <= '0;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= StIdle;
            seek_en     <= 1'b0;
            seek_target <= '0;
            acc_clear   <= 1'b0;
            dump_valid  <= 1'b0;
            bin_index   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            step_q      <= '0;
            nbins_q     <= '0;
            dwell_q     <= '0;
            dwell_cnt   <= '0;
        end else begin
            acc_clear <= 1'b0;
            done      <= 1'b0;
            cfg_err   <= 1'b0;
            if ((state != StIdle) && (abort || wd_fire)) begin
                state      <= StIdle;
                seek_en    <= 1'b0;
                dump_valid <= 1'b0;
                busy       <= 1'b0;
                cfg_err    <= !abort;
            end else begin
                case (state)
                    StIdle: begin
                        if (start && !abort) begin
                            if (!cfg_ok) begin
                                cfg_err <= 1'b1;
                            end else begin
                                step_q      <= cs_step;
                                nbins_q     <= num_bins;
                                dwell_q     <= dwell_len;
                                seek_target <= cs_start;
                                bin_index   <= '0;
                                busy        <= 1'b1;
                                if (num_bins == '0) begin
                                    state <= StFin;
                                end else begin
                                    state   <= StSeek;
                                    seek_en <= 1'b1;
                                end
                            end
                        end
                    end
                    StSeek: begin
                        if (target_reached && !seeking) begin
                            state <= StSettle;
                        end
                    end
                    // One cycle to let the upsampler's enable pipe catch up before trusting alignment.
                    StSettle: begin
                        if (target_reached) begin
                            state     <= StDwell;
                            seek_en   <= 1'b0;
                            acc_clear <= 1'b1;
                            dwell_cnt <= '0;
                        end else begin
                            state <= StSeek;
                        end
                    end
                    StDwell: begin
                        if (dwell_q == '0) begin
                            state      <= StDump;
                            dump_valid <= 1'b1;
                        end else if (sample_en) begin
                            if (dwell_cnt == (dwell_q - DWELL_WIDTH'(1))) begin
                                state      <= StDump;
                                dump_valid <= 1'b1;
                            end else begin
                                dwell_cnt <= dwell_cnt + DWELL_WIDTH'(1);
                            end
                        end
                    end
                    StDump: begin
                        if (dump_ready) begin
                            dump_valid <= 1'b0;
                            if (last_bin) begin
                                state <= StFin;
                            end else begin
                                state       <= StSeek;
                                seek_en     <= 1'b1;
                                bin_index   <= bin_index + BIN_WIDTH'(1);
                                seek_target <= nxt_wrap[CS_WIDTH-1:0];
                            end
                        end
                    end
                    StFin: begin
                        state <= StIdle;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state   <= StIdle;
                        seek_en <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_code_search_ctrl.sv
// Bench for code_search_ctrl: upsampler/accumulator environment, expected-dump scoreboard,
// directed edge cases and randomized search configurations.
module tb_code_search_ctrl;
    localparam int CS_MAX = 2045;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] cs_start = '0;
    logic [10:0] cs_step = '0;
    logic [10:0] num_bins = '0;
    logic [15:0] dwell_len = '0;
    logic        sample_en = 1'b0;
    logic        target_reached = 1'b0;
    logic        seeking = 1'b0;
    logic        seek_en;
    logic [10:0] seek_target;
    logic        acc_clear;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [10:0] bin_index;
    logic        busy;
    logic        done;
    logic        cfg_err;

    code_search_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cs_start(cs_start), .cs_step(cs_step), .num_bins(num_bins), .dwell_len(dwell_len),
        .sample_en(sample_en), .target_reached(target_reached), .seeking(seeking),
        .seek_en(seek_en), .seek_target(seek_target), .acc_clear(acc_clear),
        .dump_valid(dump_valid), .dump_ready(dump_ready), .bin_index(bin_index),
        .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct { int bin; int tgt; } exp_t;
    exp_t exp_q[$];

    int total = 0;
    int bad = 0;
    int rdy_mode = 1;  // 0 random, 1 always high, 2 follow rdy_force
    int se_mode = 1;   // 0 random, 1 always high
    bit rdy_force = 1'b0;
    bit glitch_en = 1'b0;
    int cur_dl = 0;
    int last_tgt = -1;
    int n_acc, n_dv, n_done, n_cfg;
    bit was_aborted;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Reference: bins visit cs_start, cs_start+step, ... modulo the code length.
    task automatic push_expect(input int cs0, input int stp, input int nb);
        int t = cs0;
        for (int b = 0; b < nb; b++) begin
            exp_q.push_back('{bin: b, tgt: t});
            t = (t + stp) % (CS_MAX + 1);
        end
    endtask

    task automatic do_start(input int cs0, input int stp, input int nb, input int dl);
        @(posedge clk); #2;
        start = 1'b1;
        cs_start = 11'(cs0);
        cs_step = 11'(stp);
        num_bins = 11'(nb);
        dwell_len = 16'(dl);
        cur_dl = dl;
        if (cs0 <= CS_MAX && stp <= CS_MAX) push_expect(cs0, stp, nb);
        @(posedge clk); #2;
        start = 1'b0;
    endtask

    task automatic wait_acc(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (acc_clear) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("acc_clear_timeout", 0, 1);
    endtask

    task automatic run_until_done(input int budget, input int abort_at);
        bit fin = 1'b0;
        n_acc = 0; n_dv = 0; n_done = 0; n_cfg = 0;
        was_aborted = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n_acc += int'(acc_clear); n_dv += int'(dump_valid);
            n_done += int'(done); n_cfg += int'(cfg_err);
            if (done) begin
                fin = 1'b1;
                break;
            end
            if (i == abort_at) begin
                @(posedge clk); #2; abort = 1'b1;
                @(posedge clk); #2; abort = 1'b0;
                @(negedge clk);
                chk("abort_busy", int'(busy), 0);
                chk("abort_seek_en", int'(seek_en), 0);
                chk("abort_dump_valid", int'(dump_valid), 0);
                chk("abort_done", int'(done), 0);
                exp_q.delete();
                was_aborted = 1'b1;
                break;
            end
        end
        if (!fin && !was_aborted) chk("done_timeout", 0, 1);
        if (fin) begin
            @(negedge clk);
            chk("busy_after_done", int'(busy), 0);
            n_done += int'(done);
        end
        repeat (3) begin
            @(negedge clk);
            n_done += int'(done); n_acc += int'(acc_clear); n_dv += int'(dump_valid);
        end
    endtask

    // Upsampler and accumulator stand-ins, driven just after each active edge.
    initial begin : env
        int pos;
        int lat;
        pos = 0;
        lat = -1;
        forever begin
            @(posedge clk); #1;
            if (seek_en && int'(seek_target) != pos) begin
                if (lat < 0) lat = int'($urandom_range(0, 3));
                if (lat == 0) begin
                    pos = int'(seek_target);
                    lat = -1;
                end else begin
                    lat--;
                end
            end
            seeking = seek_en && (int'(seek_target) != pos);
            target_reached = (int'(seek_target) == pos) &&
                             !(glitch_en && $urandom_range(0, 5) == 0);
            sample_en = (se_mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            dump_ready = (rdy_mode == 1) ? 1'b1 :
                         (rdy_mode == 2) ? rdy_force : 1'($urandom_range(0, 1));
        end
    end

    initial begin : mon
        bit dv_prev = 1'b0;
        bit in_dw = 1'b0;
        int cnt = 0;
        int dcyc = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                dv_prev = 1'b0;
                in_dw = 1'b0;
            end else begin
                if (acc_clear) begin
                    if (exp_q.size() == 0) begin
                        chk("acc_clear_unexpected", 1, 0);
                    end else begin
                        chk("acc_bin", int'(bin_index), exp_q[0].bin);
                        chk("acc_target", int'(seek_target), exp_q[0].tgt);
                    end
                    in_dw = 1'b1;
                    cnt = int'(sample_en);
                    dcyc = 1;
                end else if (dump_valid && !dv_prev && in_dw) begin
                    if (cur_dl > 0) chk("dwell_samples", cnt, cur_dl);
                    else chk("dwell_cycles", dcyc, 1);
                    in_dw = 1'b0;
                end else if (in_dw) begin
                    cnt += int'(sample_en);
                    dcyc++;
                end
                if (dump_valid && dump_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("dump_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("dump_bin", int'(bin_index), e.bin);
                        chk("dump_target", int'(seek_target), e.tgt);
                        last_tgt = int'(seek_target);
                    end
                end
                dv_prev = dump_valid;
            end
        end
    end

    initial begin : limit
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int hv;
        int cs0, stp, nb, dl, ab;

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_seek_en", int'(seek_en), 0);
        chk("rst_acc_clear", int'(acc_clear), 0);
        chk("rst_dump_valid", int'(dump_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_seek_target", int'(seek_target), 0);
        chk("rst_bin_index", int'(bin_index), 0);
        @(posedge clk); #2;
        reset = 1'b1;

        // Basic three-bin search
        se_mode = 0; rdy_mode = 1;
        do_start(10, 2, 3, 4);
        @(negedge clk);
        chk("start_seek_en", int'(seek_en), 1);
        chk("start_busy", int'(busy), 1);
        chk("start_target", int'(seek_target), 10);
        chk("start_bin", int'(bin_index), 0);
        run_until_done(400, -1);
        chk("basic_acc_clear", n_acc, 3);
        chk("basic_dump_cycles", n_dv, 3);
        chk("basic_done", n_done, 1);
        chk("basic_queue_empty", exp_q.size(), 0);

        // Target wrap past the last legal shift
        do_start(2044, 3, 2, 2);
        run_until_done(400, -1);
        chk("wrap_target", last_tgt, (2044 + 3) % (CS_MAX + 1));
        chk("wrap_done", n_done, 1);

        // Dump handshake held while ready is low
        se_mode = 1; rdy_mode = 2; rdy_force = 1'b0;
        do_start(100, 5, 2, 1);
        hv = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dump_valid) break;
        end
        chk("hs_first_valid", int'(dump_valid), 1);
        hv = int'(dump_valid);
        repeat (6) begin
            @(negedge clk);
            hv += int'(dump_valid);
            chk("hs_bin_stable", int'(bin_index), 0);
        end
        rdy_force = 1'b1;
        @(negedge clk);
        hv += int'(dump_valid);
        chk("hs_valid_cycles", hv, 8);
        rdy_mode = 1;
        @(negedge clk);
        chk("hs_valid_dropped", int'(dump_valid), 0);
        chk("hs_bin_advanced", int'(bin_index), 1);
        run_until_done(300, -1);
        chk("hs_done", n_done, 1);

        // Zero bins: straight to done, never seeks
        do_start(5, 1, 0, 3);
        @(negedge clk);
        chk("nb0_busy", int'(busy), 1);
        chk("nb0_seek_en_c1", int'(seek_en), 0);
        chk("nb0_done_c1", int'(done), 0);
        @(negedge clk);
        chk("nb0_done_c2", int'(done), 1);
        chk("nb0_seek_en_c2", int'(seek_en), 0);
        @(negedge clk);
        chk("nb0_busy_after", int'(busy), 0);

        // Illegal step rejected
        do_start(0, 2046, 2, 2);
        @(negedge clk);
        chk("bad_step_cfg_err", int'(cfg_err), 1);
        chk("bad_step_busy", int'(busy), 0);
        @(negedge clk);
        chk("bad_step_cfg_err_pulse", int'(cfg_err), 0);
        chk("bad_step_seek_en", int'(seek_en), 0);

        // start together with abort in IDLE is ignored
        @(posedge clk); #2;
        start = 1'b1; abort = 1'b1; cs_start = 11'd7; cs_step = 11'd1; num_bins = 11'd1;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", int'(busy), 0);
        chk("start_abort_cfg_err", int'(cfg_err), 0);

        // start during DWELL ignored
        do_start(20, 1, 2, 6);
        wait_acc(100);
        @(posedge clk); #2;
        start = 1'b1; cs_start = 11'd500; num_bins = 11'd5;
        @(posedge clk); #2;
        start = 1'b0;
        run_until_done(300, -1);
        chk("dwstart_done", n_done, 1);
        chk("dwstart_cfg_err", n_cfg, 0);
        chk("dwstart_acc_clear", n_acc, 1);
        chk("dwstart_queue_empty", exp_q.size(), 0);

        // Abort in DWELL after two of four samples
        do_start(30, 1, 3, 4);
        wait_acc(100);
        @(posedge clk); #2;
        @(posedge clk); #2; abort = 1'b1;
        @(posedge clk); #2; abort = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("abort_dw_busy", int'(busy), 0);
        chk("abort_dw_seek_en", int'(seek_en), 0);
        hv = 0;
        n_done = 0;
        repeat (10) begin
            @(negedge clk);
            hv += int'(dump_valid);
            n_done += int'(done);
        end
        chk("abort_dw_no_dump", hv, 0);
        chk("abort_dw_no_done", n_done, 0);

        // Reset mid-operation
        se_mode = 0;
        do_start(40, 7, 3, 5);
        wait_acc(100);
        @(posedge clk); #2; reset = 1'b0;
        @(posedge clk); #2; reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_seek_target", int'(seek_target), 0);
        chk("midrst_bin_index", int'(bin_index), 0);
        chk("midrst_dump_valid", int'(dump_valid), 0);

        // Randomized configurations
        rdy_mode = 0; se_mode = 0; glitch_en = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cs0 = int'($urandom_range(0, CS_MAX));
            stp = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5))
                                               : int'($urandom_range(2038, CS_MAX));
            if ($urandom_range(0, 7) == 0) cs0 = int'($urandom_range(2046, 2047));
            if ($urandom_range(0, 7) == 0) stp = int'($urandom_range(2046, 2047));
            nb = int'($urandom_range(0, 4));
            dl = int'($urandom_range(0, 5));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 40)) : -1;
            do_start(cs0, stp, nb, dl);
            if (cs0 > CS_MAX || stp > CS_MAX) begin
                @(negedge clk);
                chk("rnd_reject_cfg_err", int'(cfg_err), 1);
                chk("rnd_reject_busy", int'(busy), 0);
            end else begin
                run_until_done(600, ab);
                if (!was_aborted) begin
                    chk("rnd_done", n_done, 1);
                    chk("rnd_queue_empty", exp_q.size(), 0);
                end else begin
                    chk("rnd_abort_no_done", n_done, 0);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
